// File: rtl/fnd_time_display_if.sv
// Time fields in from the clock counter, multiplexed FND pins out.
// Master drives the time fields; the display driver (slave) drives the pins.
interface fnd_time_display_if;
  logic [5:0] i_hour;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic [6:0] i_msec;
  logic       i_mode;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_font;

  modport master (
    output i_hour, i_min, i_sec, i_msec, i_mode,
    input  o_fnd_com, o_fnd_font
  );

  modport slave (
    input  i_hour, i_min, i_sec, i_msec, i_mode,
    output o_fnd_com, o_fnd_font
  );
endinterface

// File: rtl/fnd_time_display.sv
// 4-digit common-anode FND scanner; the time fields are snapshotted once per frame so frames never tear.
// Outputs registered one cycle after digit index/snapshot; no backpressure, inputs are sampled free-running.
module fnd_time_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  fnd_time_display_if.slave bus
);

  localparam int PC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] msec;
    logic       mode;
  } snap_t;

  logic [PC_W-1:0] pc;
  logic [1:0]      d;
  snap_t           snap;
  logic            tick;

  logic [6:0] hi_val;
  logic [6:0] lo_val;
  logic [6:0] fld;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] digit;
  logic       dash;
  logic       dp_on;
  logic [6:0] seg;
  logic [3:0] com_nxt;
  logic [7:0] font_nxt;

  assign tick = (pc == PC_LAST);

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] seg_of(input logic [3:0] dig, input logic is_dash);
    logic [6:0] s;
    s = 7'h7F;
    if (is_dash) begin
      s = 7'h3F;
    end else begin
      case (dig)
        4'd0:    s = 7'h40;
        4'd1:    s = 7'h79;
        4'd2:    s = 7'h24;
        4'd3:    s = 7'h30;
        4'd4:    s = 7'h19;
        4'd5:    s = 7'h12;
        4'd6:    s = 7'h02;
        4'd7:    s = 7'h78;
        4'd8:    s = 7'h00;
        4'd9:    s = 7'h10;
        default: s = 7'h7F;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    hi_val   = snap.mode ? {1'b0, snap.sec} : {1'b0, snap.hour};
    lo_val   = snap.mode ? snap.msec : {1'b0, snap.min};
    fld      = d[1] ? hi_val : lo_val;
    ones     = 4'(fld % 7'd10);
    tens     = 4'(fld / 7'd10);
    digit    = d[0] ? tens : ones;
    // Only the 7-bit msec field can exceed two decimal digits.
    dash     = (fld > 7'd99);
    dp_on    = (d == 2'd2) && (snap.mode || (snap.msec < 7'd50));
    seg      = seg_of(digit, dash);
    com_nxt  = ~(4'b0001 << d);
    font_nxt = {~dp_on, seg};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pc             <= '0;
      d              <= 2'd0;
      snap           <= '0;
      bus.o_fnd_com  <= 4'hF;
      bus.o_fnd_font <= 8'hFF;
    end else begin
      pc <= tick ? '0 : pc + PC_W'(1);
      if (tick) begin
        d <= d + 2'd1;
        if (d == 2'd3) begin
          snap <= '{hour: bus.i_hour, min: bus.i_min, sec: bus.i_sec,
                    msec: bus.i_msec, mode: bus.i_mode};
        end
      end
      // com and font move together on one edge, so no ghost digit appears.
      bus.o_fnd_com  <= com_nxt;
      bus.o_fnd_font <= font_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_time_display.sv
// Bench for fnd_time_display: directed vector table, hand sequences, and a random run against a frame-level model.
module tb_fnd_time_display;

  localparam int SD = 4;
  localparam logic [7:0] FONT [0:10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                         8'h82, 8'hF8, 8'h80, 8'h90, 8'hBF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fnd_time_display_if tif();

  fnd_time_display #(.SCAN_DIV(SD)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (tif.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int hour;
    int min;
    int sec;
    int msec;
    int mode;
    logic [31:0] fonts; // {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs [4];

  // Display content for digit position dd given a frame's captured fields.
  function automatic logic [11:0] ref_out(int dd, int hour, int min, int sec, int msec, int mode);
    int v;
    int code;
    logic [7:0] f;
    v = (dd < 2) ? ((mode != 0) ? msec : min) : ((mode != 0) ? sec : hour);
    if (v > 99) code = 10;
    else code = ((dd % 2) == 0) ? (v % 10) : (v / 10);
    f = FONT[code];
    if (dd == 2 && (mode != 0 || msec < 50)) f[7] = 1'b0;
    return {~(4'b0001 << dd), f};
  endfunction

  // Frame-level model: k counts edges since reset release; the frame wraps every 4*SD edges.
  int k = 0;
  int s_hour = 0, s_min = 0, s_sec = 0, s_msec = 0, s_mode = 0;
  logic [3:0] e_com = 4'hF;
  logic [7:0] e_font = 8'hFF;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      s_hour = 0; s_min = 0; s_sec = 0; s_msec = 0; s_mode = 0;
      e_com = 4'hF;
      e_font = 8'hFF;
    end else begin
      k = k + 1;
      {e_com, e_font} = ref_out(((k - 1) / SD) % 4, s_hour, s_min, s_sec, s_msec, s_mode);
      if (k % (4 * SD) == 0) begin
        s_hour = int'(tif.i_hour);
        s_min  = int'(tif.i_min);
        s_sec  = int'(tif.i_sec);
        s_msec = int'(tif.i_msec);
        s_mode = int'(tif.i_mode);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] c, input logic [7:0] f);
    n_chk++;
    if (tif.o_fnd_com !== c || tif.o_fnd_font !== f) begin
      n_fail++;
      $display("FAIL %s @%0t: got com=%b font=%h, want com=%b font=%h",
               nm, $time, tif.o_fnd_com, tif.o_fnd_font, c, f);
    end
  endtask

  always @(negedge clk) chk("model", e_com, e_font);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int h, input int m, input int s, input int ms, input int md);
    tif.i_hour = 6'(h);
    tif.i_min  = 6'(m);
    tif.i_sec  = 6'(s);
    tif.i_msec = 7'(ms);
    tif.i_mode = 1'(md);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset_hold", 4'hF, 8'hFF);
    end
    rst_n = 1'b1;
    step(1);
    chk("reset_release", 4'b1110, 8'hC0);
  endtask

  initial begin
    vecs[0] = '{hour: 12, min: 34, sec: 0,  msec: 10,  mode: 0, fonts: {8'hF9, 8'h24, 8'hB0, 8'h99}};
    vecs[1] = '{hour: 12, min: 34, sec: 0,  msec: 75,  mode: 0, fonts: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[2] = '{hour: 0,  min: 0,  sec: 59, msec: 7,   mode: 1, fonts: {8'h92, 8'h10, 8'hC0, 8'hF8}};
    vecs[3] = '{hour: 0,  min: 0,  sec: 59, msec: 120, mode: 1, fonts: {8'h92, 8'h10, 8'hBF, 8'hBF}};

    set_in(0, 0, 0, 0, 0);

    // Reset and first digit advance.
    do_reset();
    step(SD - 1);
    chk("d_hold", 4'b1110, 8'hC0);
    step(1);
    chk("d_advance", 4'b1101, 8'hC0);

    // Vector table: inputs held across two frames, second frame checked.
    for (int v = 0; v < 4; v++) begin
      logic [31:0] fw;
      set_in(vecs[v].hour, vecs[v].min, vecs[v].sec, vecs[v].msec, vecs[v].mode);
      do_reset();
      step(4 * SD);
      fw = vecs[v].fonts;
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("vec%0d_d%0d", v, j), ~(4'b0001 << j), fw[8*j +: 8]);
        step(SD);
      end
    end

    // Tear-free: fields change while d1 is displayed.
    set_in(12, 34, 0, 10, 0);
    do_reset();
    step(4 * SD + SD);
    set_in(23, 59, 0, 10, 0);
    chk("tear_d1", 4'b1101, 8'hB0);
    step(SD);
    chk("tear_d2", 4'b1011, 8'h24);
    step(SD);
    chk("tear_d3", 4'b0111, 8'hF9);
    step(SD);
    chk("next_d0", 4'b1110, 8'h90);
    step(SD);
    chk("next_d1", 4'b1101, 8'h92);
    step(SD);
    chk("next_d2", 4'b1011, 8'h30);
    step(SD);
    chk("next_d3", 4'b0111, 8'hA4);

    // Reset mid-scan while d2 is shown.
    set_in(0, 0, 59, 120, 1);
    do_reset();
    step(4 * SD + 2 * SD + 1);
    chk("pre_midreset_d2", 4'b1011, 8'h10);
    rst_n = 1'b0;
    step(1);
    chk("midreset", 4'hF, 8'hFF);
    rst_n = 1'b1;
    step(1);
    chk("restart_d0", 4'b1110, 8'hC0);
    step(SD - 1);
    chk("restart_hold", 4'b1110, 8'hC0);
    step(1);
    chk("restart_d1", 4'b1101, 8'hC0);

    // Random fields, mode flips and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)
        set_in(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 1)));
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    rst_n = 1'b1;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_time_display.md
# fnd_time_display

Multiplexed 4-digit seven-segment (FND) driver that consumes the hour/min/sec/msec fields produced by the time-clock counter. It presents them as decimal digits on a common-anode display. It sits between the counter outputs and the board's FND pins. It scans one digit per scan tick and snapshots the time fields once per frame, so a displayed frame never mixes old and new values. A mode input selects the HH.MM view or the SS.cc view.

## Interface
- SCAN_DIV, 100000, clock cycles per digit-scan tick; must be ≥ 2. At 100 MHz the default gives a 1 kHz digit rate and a 250 Hz frame rate.
- i_clk  input  1  system clock, all logic on rising edge
- i_reset_n  input  1  reset; one clock; reset is synchronous and active-low
- i_hour  input  6  hours, 0–23 nominal
- i_min  input  6  minutes, 0–59 nominal
- i_sec  input  6  seconds, 0–59 nominal
- i_msec  input  7  hundredths of a second, 0–99 nominal
- i_mode  input  1  0 = high field hour, low field min; 1 = high field sec, low field msec
- o_fnd_com  output  4  digit enables, active-low; bit n drives digit n, digit 0 is rightmost
- o_fnd_font  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}

## Operation
- **Prescaler**
  - Counter `pc` counts 0..SCAN_DIV-1 and wraps to 0.
  - `tick` is asserted in the cycle where pc == SCAN_DIV-1.
- **Digit index**
  - 2-bit index `d` advances by one on each tick: 0→1→2→3→0.
- **Snapshot**
  - On a tick with d == 3 (the frame wrap), the block registers i_hour, i_min, i_sec, i_msec and i_mode into the snapshot.
  - All digit content comes from the snapshot only.
  - Input changes mid-frame are therefore invisible until the next frame.
- **Field select (from the snapshot)**
  - mode 0: high field = hour, low field = min.
  - mode 1: high field = sec, low field = msec.
- **Digit mapping**
  - d = 0: low field ones digit.
  - d = 1: low field tens digit.
  - d = 2: high field ones digit.
  - d = 3: high field tens digit.
  - Ones = v mod 10; tens = v / 10. Values 0–99 give two digits, and leading zeros are shown.
- **Range guard**
  - A field value > 99 (possible only on the 7-bit msec field) displays a dash (g only) on both of its digits.
- **Decimal point (lit only on d = 2)**
  - mode 0: lit when snapshot msec < 50, giving a 1 Hz blink.
  - mode 1: always lit.
- **Font, dp off**
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF.
  - dp on clears bit 7 (for example 2 with dp = 24).
- **Digit enable**
  - o_fnd_com = ~(4'b0001 << d); exactly one bit is low outside reset.

## Timing
- **Reset values** (with i_reset_n low at a clock edge):
  - pc = 0, d = 0, snapshot = all zeros including mode.
  - o_fnd_com = 4'b1111 (all digits dark), o_fnd_font = 8'hFF.
- **After reset**
  - On the first edge with i_reset_n high, the outputs become the registered function of d = 0 and the zero snapshot: com = 1110, font = C0.
- **Output register**
  - o_fnd_com and o_fnd_font are registered from (d, snapshot).
  - They change exactly one clock after d or the snapshot changes, and com and font change on the same edge, so there is no ghost digit.
- **First tick**
  - The first tick occurs SCAN_DIV cycles after reset release.
  - Each digit is then held for SCAN_DIV cycles.
- **Snapshot timing**
  - The snapshot taken at the d = 3 tick is visible from d = 0 of the next frame, which appears on the outputs one cycle after the tick's edge.
- **Reset mid-scan**
  - Reset mid-scan takes effect at the next edge, with no partial completion.
  - The scan restarts at d = 0 with a fresh prescaler.
- **i_mode changes**
  - i_mode changes are honoured only at the frame wrap.

## Test plan
- **Reset**: SCAN_DIV=4; hold i_reset_n low 3 cycles → com=1111, font=FF each cycle. Release → next edge com=1110, font=C0. d advances 4 cycles later.
- **mode 0**: hour=12, min=34, msec=10 held for 2 frames. In the second frame, expect (com,font) = d0 (1110,99), d1 (1101,B0), d2 (1011,24), d3 (0111,F9).
- **Blink**: same as the mode 0 scenario but msec=75 → d2 font=A4 (dp off); all other digits unchanged.
- **mode 1**: sec=59, msec=7 → d0 F8, d1 C0, d2 10, d3 92.
- **Tear-free**: change hour/min from 12:34 to 23:59 while d=1 → d2 and d3 of that frame still show 2 (dp per msec) and 1. The next frame shows 9, 5, 3 and 2 on d0–d3.
- **Range/reset**: mode 1, msec=120 → d0 and d1 font=BF. Then assert i_reset_n low while d=2 → outputs are 1111/FF on the next edge, and the scan restarts at d0.
